// File: rtl/ahb_slave_mem_if.sv
// ahb_slave_mem_if: one AHB slave port as seen from the interconnect.
// The master modport drives the address/data phase and the slave modport returns HRDATA/HREADY/HRESP.
interface ahb_slave_mem_if;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [2:0]  HPROT;
  logic [2:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HWDATA,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB word memory slave with byte/half/word lane writes and a 2-cycle ERROR response.
// Latency WAIT_STATES+1 cycles per OKAY transfer (ERROR: 2); HREADY low stalls the master.
module ahb_slave_mem #(
  parameter logic [1:0] SLAVE_ID    = 2'd0,
  parameter int         DEPTH       = 256,
  parameter int         WAIT_STATES = 0
) (
  input logic            HCLK,
  input logic            HRST,
  ahb_slave_mem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_wcnt;
  logic [AW-1:0] r_idx;
  logic [1:0]    r_lsb;
  logic [1:0]    r_size;
  logic          r_write;
  logic [31:0]   r_mem [DEPTH];

  logic          w_open;
  logic          w_sel;
  logic          w_accept;
  logic          w_err;
  logic [3:0]    w_be;
  logic          w_wr_en;
  logic          w_hready;
  logic          w_hresp;
  logic [31:0]   w_hrdata;
  logic          w_unused;

  assign w_unused = ^{bus.HBURST, bus.HPROT, bus.HTRANS[2], bus.HTRANS[0]};

  // A new address phase can only be taken in cycles where HREADY is high.
  assign w_open   = (r_state == S_IDLE) || (r_state == S_DATA) || (r_state == S_ERR2);
  assign w_sel    = bus.HTRANS[1] && (bus.HADDR[31:30] == SLAVE_ID);
  assign w_accept = w_open && w_sel;

  always_comb begin
    w_err = 1'b0;
    if (bus.HSIZE > 3'd2)                              w_err = 1'b1;
    if (bus.HSIZE == 3'd1 && bus.HADDR[0])             w_err = 1'b1;
    if (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)  w_err = 1'b1;
    if ({4'b0000, bus.HADDR[29:2]} >= 32'(DEPTH))      w_err = 1'b1;
  end

  always_ff @(posedge HCLK) begin
    if (HRST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DATA, S_ERR2: begin
        if (!w_accept)             w_next = S_IDLE;
        else if (w_err)            w_next = S_ERR1;
        else if (WAIT_STATES > 0)  w_next = S_WAIT;
        else                       w_next = S_DATA;
      end
      S_WAIT:  if (r_wcnt == 4'd1) w_next = S_DATA;
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRST) begin
      r_wcnt  <= 4'd0;
      r_idx   <= '0;
      r_lsb   <= 2'd0;
      r_size  <= 2'd0;
      r_write <= 1'b0;
    end else if (w_accept) begin
      r_wcnt  <= 4'(WAIT_STATES);
      r_idx   <= bus.HADDR[AW+1:2];
      r_lsb   <= bus.HADDR[1:0];
      r_size  <= bus.HSIZE[1:0];
      r_write <= bus.HWRITE;
    end else if (r_state == S_WAIT) begin
      r_wcnt  <= r_wcnt - 4'd1;
    end
  end

  // Little-endian lane selection; illegal sizes never reach DATA.
  always_comb begin
    w_be = 4'b0000;
    case (r_size)
      2'd0:    w_be = 4'b0001 << r_lsb;
      2'd1:    w_be = r_lsb[1] ? 4'b1100 : 4'b0011;
      default: w_be = 4'b1111;
    endcase
  end

  assign w_wr_en = (r_state == S_DATA) && r_write && !HRST;

  always_ff @(posedge HCLK) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[r_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
      end
    end
  end

  // Combinational read lands after the previous write's closing edge, so read-after-write needs no bypass.
  always_comb begin
    w_hready = 1'b1;
    w_hresp  = 1'b0;
    w_hrdata = 32'd0;
    case (r_state)
      S_WAIT: w_hready = 1'b0;
      S_DATA: if (!r_write) w_hrdata = r_mem[r_idx];
      S_ERR1: begin
        w_hready = 1'b0;
        w_hresp  = 1'b1;
      end
      S_ERR2: w_hresp = 1'b1;
      default: ;
    endcase
  end

  assign bus.HREADY = w_hready;
  assign bus.HRESP  = w_hresp;
  assign bus.HRDATA = w_hrdata;
endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: two slaves (WAIT_STATES 0 and 3) driven by directed and random AHB traffic,
// checked every cycle against a transaction-level model with a byte-addressed memory.
module tb_ahb_slave_mem;
  logic clk  = 1'b0;
  logic hrst = 1'b1;
  always #5 clk = ~clk;

  ahb_slave_mem_if bus0 ();
  ahb_slave_mem_if bus1 ();

  logic [31:0] s_addr [2];
  logic        s_wr [2];
  logic [2:0]  s_size [2];
  logic [2:0]  s_trans [2];
  logic [2:0]  s_burst [2];
  logic [2:0]  s_prot [2];
  logic [31:0] s_wd [2];
  logic [31:0] o_rd [2];
  logic        o_rdy [2];
  logic        o_resp [2];

  assign bus0.HADDR  = s_addr[0];  assign bus1.HADDR  = s_addr[1];
  assign bus0.HWRITE = s_wr[0];    assign bus1.HWRITE = s_wr[1];
  assign bus0.HSIZE  = s_size[0];  assign bus1.HSIZE  = s_size[1];
  assign bus0.HTRANS = s_trans[0]; assign bus1.HTRANS = s_trans[1];
  assign bus0.HBURST = s_burst[0]; assign bus1.HBURST = s_burst[1];
  assign bus0.HPROT  = s_prot[0];  assign bus1.HPROT  = s_prot[1];
  assign bus0.HWDATA = s_wd[0];    assign bus1.HWDATA = s_wd[1];
  assign o_rd[0]   = bus0.HRDATA;  assign o_rd[1]   = bus1.HRDATA;
  assign o_rdy[0]  = bus0.HREADY;  assign o_rdy[1]  = bus1.HREADY;
  assign o_resp[0] = bus0.HRESP;   assign o_resp[1] = bus1.HRESP;

  ahb_slave_mem #(.SLAVE_ID(2'd1), .DEPTH(256), .WAIT_STATES(0)) dut0 (.HCLK(clk), .HRST(hrst), .bus(bus0));
  ahb_slave_mem #(.SLAVE_ID(2'd1), .DEPTH(256), .WAIT_STATES(3)) dut1 (.HCLK(clk), .HRST(hrst), .bus(bus1));

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Model: one outstanding transfer per slave, counted down in cycles until it completes.
  logic [7:0]  mm [2][1024];
  bit          mk [2][1024];
  bit          p_act [2];
  int          p_cnt [2];
  bit          p_err [2];
  bit          p_wr [2];
  logic [31:0] p_addr [2];
  int          p_size [2];
  bit          started = 1'b0;
  int          m_n, m_b, m_base;
  bit          m_rdy;

  function automatic int ws(input int k);
    return (k == 1) ? 3 : 0;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic [2:0] sz);
    if (sz > 3'd2) return 1'b1;
    if ((int'(a[1:0]) % (1 << sz)) != 0) return 1'b1;
    if (int'(a[29:2]) >= 256) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    if (hrst) started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (hrst) begin
        p_act[k] = 1'b0;
      end else begin
        m_rdy = !p_act[k] || (p_cnt[k] == 1);
        if (p_act[k] && p_cnt[k] == 1 && !p_err[k] && p_wr[k]) begin
          m_n    = 1 << p_size[k];
          m_base = int'(p_addr[k][9:0]);
          m_base = m_base - (m_base % m_n);
          for (int j = 0; j < m_n; j++) begin
            m_b = m_base + j;
            mm[k][m_b] = s_wd[k][8*(m_b%4) +: 8];
            mk[k][m_b] = 1'b1;
          end
        end
        if (p_act[k]) begin
          p_cnt[k] = p_cnt[k] - 1;
          if (p_cnt[k] == 0) p_act[k] = 1'b0;
        end
        if (m_rdy && s_trans[k][1] && s_addr[k][31:30] == 2'd1) begin
          p_act[k]  = 1'b1;
          p_err[k]  = is_err(s_addr[k], s_size[k]);
          p_cnt[k]  = p_err[k] ? 2 : ws(k) + 1;
          p_wr[k]   = s_wr[k];
          p_addr[k] = s_addr[k];
          p_size[k] = int'(s_size[k]);
        end
      end
    end
  end

  task automatic expect_out(input int k, output bit rdy, output bit resp,
                            output logic [31:0] rd, output logic [31:0] mask);
    int w;
    rdy = 1'b1; resp = 1'b0; rd = 32'd0; mask = 32'hFFFF_FFFF;
    if (p_act[k]) begin
      rdy  = (p_cnt[k] == 1);
      resp = p_err[k];
      if (p_cnt[k] == 1 && !p_err[k] && !p_wr[k]) begin
        w = int'(p_addr[k][9:2]) * 4;
        for (int j = 0; j < 4; j++) begin
          rd[8*j +: 8]   = mm[k][w+j];
          mask[8*j +: 8] = mk[k][w+j] ? 8'hFF : 8'h00;
        end
      end
    end
  endtask

  bit          c_rdy, c_resp;
  logic [31:0] c_rd, c_mask;

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        expect_out(k, c_rdy, c_resp, c_rd, c_mask);
        n_chk++;
        if (o_rdy[k] !== c_rdy) begin
          n_fail++;
          $display("FAIL hready dut%0d t=%0t got %b exp %b", k, $time, o_rdy[k], c_rdy);
        end else n_pass++;
        n_chk++;
        if (o_resp[k] !== c_resp) begin
          n_fail++;
          $display("FAIL hresp dut%0d t=%0t got %b exp %b", k, $time, o_resp[k], c_resp);
        end else n_pass++;
        n_chk++;
        if (((o_rd[k] ^ c_rd) & c_mask) !== 32'd0) begin
          n_fail++;
          $display("FAIL hrdata dut%0d t=%0t got %h exp %h mask %h", k, $time, o_rd[k], c_rd, c_mask);
        end else n_pass++;
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end else n_pass++;
  endtask

  task automatic timeout(input string nm, input int k);
    n_chk++;
    n_fail++;
    $display("FAIL %s dut%0d timed out waiting for HREADY", nm, k);
  endtask

  // Present an address phase until HREADY takes it; junk may be shown during stalled cycles.
  task automatic issue(input int k, input logic [2:0] tr, input logic [31:0] a, input logic w,
                       input logic [2:0] sz, input logic [31:0] d, input bit scr);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      s_burst[k] = 3'($urandom);
      s_prot[k]  = 3'($urandom);
      if (o_rdy[k] || !scr) begin
        s_trans[k] = tr; s_addr[k] = a; s_wr[k] = w; s_size[k] = sz;
      end else begin
        s_trans[k] = 3'($urandom); s_addr[k] = {2'b01, 30'($urandom)};
        s_wr[k] = 1'($urandom); s_size[k] = 3'($urandom);
      end
      if (o_rdy[k]) begin
        @(posedge clk);
        #1;
        s_wd[k] = d;
        done = 1'b1;
      end
    end
    if (!done) timeout("issue", k);
  endtask

  task automatic finish_xfer(input int k, input bit junk, output logic [31:0] rd, output int lows,
                             output bit rsp_first, output bit rsp_last);
    bit done;
    done = 1'b0; lows = 0; rd = 32'd0; rsp_first = 1'b0; rsp_last = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (i == 0) rsp_first = o_resp[k];
      if (o_rdy[k]) begin
        s_trans[k] = 3'd0;
        rd = o_rd[k];
        rsp_last = o_resp[k];
        done = 1'b1;
      end else begin
        lows++;
        if (junk) begin
          s_trans[k] = 3'($urandom); s_addr[k] = {2'b01, 30'($urandom)}; s_wr[k] = 1'($urandom);
        end else s_trans[k] = 3'd0;
      end
    end
    if (!done) timeout("finish", k);
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) begin
      @(negedge clk);
      s_trans[k] = 3'd0;
    end
  endtask

  task automatic wr(input int k, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    issue(k, 3'd2, a, 1'b1, sz, d, 1'b0);
  endtask

  task automatic rd_lit(input int k, input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d; int l; bit r0, r1;
    issue(k, 3'd2, a, 1'b0, 3'd2, $urandom, 1'b0);
    finish_xfer(k, 1'b0, d, l, r0, r1);
    lit(nm, d, exp);
  endtask

  task automatic err_lit(input int k, input string nm, input logic [31:0] a, input logic [2:0] sz);
    logic [31:0] d; int l; bit r0, r1;
    issue(k, 3'd2, a, 1'b1, sz, 32'hFFFF_FFFF, 1'b0);
    finish_xfer(k, 1'b0, d, l, r0, r1);
    lit({nm, "_lowcycles"}, l, 1);
    lit({nm, "_resp1"}, r0, 1);
    lit({nm, "_resp2"}, r1, 1);
  endtask

  initial begin
    logic [31:0] d, a;
    int l, sel, sz;
    bit r0, r1;
    for (int k = 0; k < 2; k++) begin
      s_addr[k] = 32'd0; s_wr[k] = 1'b0; s_size[k] = 3'd0; s_trans[k] = 3'd0;
      s_burst[k] = 3'd0; s_prot[k] = 3'd0; s_wd[k] = 32'd0;
    end
    repeat (3) @(posedge clk);
    #1 hrst = 1'b0;
    @(negedge clk);
    lit("rst_hready", o_rdy[0], 1);
    lit("rst_hresp", o_resp[1], 0);
    lit("rst_hrdata", o_rd[0], 0);

    // Zero-wait slave: back-to-back write/read, lane merges, error responses, ignored transfers.
    wr(0, 32'h4000_0010, 3'd2, 32'hDEAD_BEEF);
    rd_lit(0, "b2b_raw", 32'h4000_0010, 32'hDEAD_BEEF);
    wr(0, 32'h4000_0010, 3'd2, 32'h1122_3344);
    wr(0, 32'h4000_0013, 3'd0, {4{8'hAA}});
    rd_lit(0, "byte_merge", 32'h4000_0010, 32'hAA22_3344);
    wr(0, 32'h4000_0010, 3'd1, {2{16'hBEEF}});
    rd_lit(0, "half_merge", 32'h4000_0010, 32'hAA22_BEEF);
    wr(0, 32'h4000_0000, 3'd2, 32'h0BAD_F00D);
    err_lit(0, "err_misalign", 32'h4000_0002, 3'd2);
    err_lit(0, "err_size3", 32'h4000_0000, 3'd3);
    err_lit(0, "err_range", 32'h4000_0400, 3'd2);
    rd_lit(0, "err_nowrite", 32'h4000_0000, 32'h0BAD_F00D);
    issue(0, 3'd2, 32'h8000_0000, 1'b1, 3'd2, 32'h1234_5678, 1'b0);
    issue(0, 3'd1, 32'h4000_0000, 1'b1, 3'd2, 32'h8765_4321, 1'b0);
    idle(0, 2);
    rd_lit(0, "noselect_nowrite", 32'h4000_0000, 32'h0BAD_F00D);

    // Three-wait slave: stall length with junk on the bus, error timing, reset mid-transfer.
    wr(1, 32'h4000_0020, 3'd2, 32'h5566_7788);
    issue(1, 3'd2, 32'h4000_0020, 1'b0, 3'd2, 32'd0, 1'b0);
    finish_xfer(1, 1'b1, d, l, r0, r1);
    lit("ws3_lowcycles", l, 3);
    lit("ws3_rdata", d, 32'h5566_7788);
    err_lit(1, "ws3_err", 32'h4000_0002, 3'd2);
    issue(1, 3'd2, 32'h4000_0020, 1'b1, 3'd2, 32'h9999_9999, 1'b0);
    @(negedge clk);
    s_trans[1] = 3'd0;
    @(negedge clk);
    hrst = 1'b1;
    @(negedge clk);
    hrst = 1'b0;
    lit("rstmid_hready", o_rdy[1], 1);
    lit("rstmid_hresp", o_resp[1], 0);
    lit("rstmid_hrdata", o_rd[1], 0);
    rd_lit(1, "rstmid_oldval", 32'h4000_0020, 32'h5566_7788);

    // Random traffic into a 16-word window, with illegal and unselected transfers mixed in.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 250; i++) begin
        sel = $urandom_range(0, 19);
        sz  = $urandom_range(0, 2);
        a   = 32'h4000_0000 | (32'($urandom_range(0, 15)) << 2);
        a   = a | (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 32'd1));
        case (sel)
          0: a = {2'b10, a[29:0]};
          1: a = {2'b00, a[29:0]};
          2: sz = 3 + $urandom_range(0, 4);
          3: a = {a[31:2], 2'b01};
          4: a = a | 32'h0000_0400;
          default: ;
        endcase
        issue(k, (sel == 5) ? 3'd1 : {2'b01, 1'($urandom)}, a, 1'($urandom), 3'(sz),
              $urandom, ($urandom_range(0, 3) == 0));
        if ($urandom_range(0, 7) == 0) idle(k, $urandom_range(1, 3));
      end
      idle(k, 8);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
